// File: rtl/guess_scorer_pkg.sv
// Shared definitions for the challenge path: round states and default challenge geometry.
// Also imported by the challenge generator so both ends agree on symbol packing.
package guess_scorer_pkg;

  localparam int unsigned DefDigits = 3;
  localparam int unsigned DefSymW   = 2;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StArmed = 2'd1;
  localparam state_t StJudge = 2'd2;

endpackage

// File: rtl/guess_scorer_key_debouncer.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, and a one-cycle
// event on each debounced press (high-to-low). Releases produce no event.
module guess_scorer_key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic clear_b,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    // Counter only runs while the synchronized key disagrees; any bounce restarts it.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/guess_scorer.sv
// Challenge consumer: accepts a challenge, waits for a debounced guess submission or
// a timeout, then scores the round into per-digit lamps and saturating hit/miss counts.
module guess_scorer
  import guess_scorer_pkg::*;
#(
  parameter int unsigned DIGITS          = DefDigits,
  parameter int unsigned SYM_W           = DefSymW,
  parameter int unsigned SCORE_W         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    clear_b,
  input  logic                    chal_valid,
  input  logic [DIGITS*SYM_W-1:0] chal_sym,
  output logic                    chal_ready,
  input  logic                    submit_n,
  input  logic [DIGITS*SYM_W-1:0] guess,
  input  logic                    time_up,
  output logic [DIGITS-1:0]       match,
  output logic [SCORE_W-1:0]      hit_count,
  output logic [SCORE_W-1:0]      miss_count,
  output logic                    hit,
  output logic                    round_done
);

  localparam logic [SCORE_W-1:0] ScoreMax = '1;

  state_t                    state_q, state_d;
  logic [DIGITS*SYM_W-1:0]   chal_q, chal_d;
  logic [DIGITS*SYM_W-1:0]   guess_q, guess_d;
  logic [DIGITS-1:0]         match_q, match_d;
  logic [DIGITS-1:0]         digit_eq;
  logic [SCORE_W-1:0]        hit_cnt_q, hit_cnt_d;
  logic [SCORE_W-1:0]        miss_cnt_q, miss_cnt_d;
  logic                      hit_q, hit_d;
  logic                      done_q, done_d;
  logic                      ready_q, ready_d;
  logic                      press_event;

  guess_scorer_key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_submit_debounce (
    .clk    (clk),
    .clear_b(clear_b),
    .key_n  (submit_n),
    .press  (press_event)
  );

  always_comb begin
    digit_eq = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      digit_eq[i] = (guess_q[i*SYM_W +: SYM_W] == chal_q[i*SYM_W +: SYM_W]);
    end
  end

  always_comb begin
    state_d    = state_q;
    chal_d     = chal_q;
    guess_d    = guess_q;
    match_d    = match_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    hit_d      = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (chal_valid && ready_q) begin
          chal_d  = chal_sym;
          state_d = StArmed;
        end
      end
      StArmed: begin
        // A press in the same cycle as time_up takes priority.
        if (press_event) begin
          guess_d = guess;
          state_d = StJudge;
        end else if (time_up) begin
          match_d = '0;
          if (miss_cnt_q != ScoreMax) miss_cnt_d = miss_cnt_q + SCORE_W'(1);
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StJudge: begin
        match_d = digit_eq;
        if (&digit_eq) begin
          if (hit_cnt_q != ScoreMax) hit_cnt_d = hit_cnt_q + SCORE_W'(1);
          hit_d = 1'b1;
        end else begin
          if (miss_cnt_q != ScoreMax) miss_cnt_d = miss_cnt_q + SCORE_W'(1);
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state_q    <= StIdle;
      chal_q     <= '0;
      guess_q    <= '0;
      match_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      hit_q      <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      chal_q     <= chal_d;
      guess_q    <= guess_d;
      match_q    <= match_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      hit_q      <= hit_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign chal_ready = ready_q;
  assign match      = match_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign hit        = hit_q;
  assign round_done = done_q;

endmodule

// File: tb/tb_guess_scorer.sv
// Directed bench for guess_scorer with a short debounce window; each task drives one
// scenario and checks against hand-derived expectations.
module tb_guess_scorer;

  logic       clk = 1'b0;
  logic       clear_b = 1'b0;
  logic       chal_valid = 1'b0;
  logic [5:0] chal_sym = '0;
  logic       chal_ready;
  logic       submit_n = 1'b1;
  logic [5:0] guess = '0;
  logic       time_up = 1'b0;
  logic [2:0] match;
  logic [7:0] hit_count;
  logic [7:0] miss_count;
  logic       hit;
  logic       round_done;

  int n_vec = 0;
  int n_err = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  guess_scorer #(
    .DIGITS         (3),
    .SYM_W          (2),
    .SCORE_W        (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .clear_b   (clear_b),
    .chal_valid(chal_valid),
    .chal_sym  (chal_sym),
    .chal_ready(chal_ready),
    .submit_n  (submit_n),
    .guess     (guess),
    .time_up   (time_up),
    .match     (match),
    .hit_count (hit_count),
    .miss_count(miss_count),
    .hit       (hit),
    .round_done(round_done)
  );

  task automatic load_challenge(input logic [5:0] c);
    @(negedge clk);
    chal_sym   = c;
    chal_valid = 1'b1;
    @(negedge clk);
    chal_valid = 1'b0;
  endtask

  // Holds the button low until round_done (bounded), then releases and lets it settle.
  task automatic press_wait(output bit found, output logic [2:0] m, output logic h,
                            output logic rdy, output logic rd_after);
    found = 1'b0; m = '0; h = 1'b0; rdy = 1'b0; rd_after = 1'b1;
    submit_n = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (round_done) begin
        found = 1'b1; m = match; h = hit; rdy = chal_ready;
      end
    end
    if (found) begin
      @(negedge clk);
      rd_after = round_done;
    end
    submit_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    clear_b = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (chal_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", chal_ready); end
    n_vec++; if (match !== 3'b000) begin n_err++; $display("FAIL reset_match got %b want 000", match); end
    n_vec++; if (hit_count !== 8'd0) begin n_err++; $display("FAIL reset_hits got %0d want 0", hit_count); end
    n_vec++; if (miss_count !== 8'd0) begin n_err++; $display("FAIL reset_misses got %0d want 0", miss_count); end
    n_vec++; if ({hit, round_done} !== 2'b00) begin n_err++; $display("FAIL reset_pulses got %b want 00", {hit, round_done}); end
    clear_b = 1'b1;
    @(negedge clk);
    n_vec++; if (chal_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b want 1", chal_ready); end
  endtask

  task automatic test_full_match();
    bit found; logic [2:0] m; logic h, rdy, rda;
    load_challenge(6'b10_01_00);
    n_vec++; if (chal_ready !== 1'b0) begin n_err++; $display("FAIL armed_ready got %b want 0", chal_ready); end
    guess = 6'b10_01_00;
    press_wait(found, m, h, rdy, rda);
    exp_hit++;
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL hit_round_done got %b want 1", found); end
    n_vec++; if (m !== 3'b111) begin n_err++; $display("FAIL hit_match got %b want 111", m); end
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL hit_pulse got %b want 1", h); end
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL hit_ready got %b want 1", rdy); end
    n_vec++; if (rda !== 1'b0) begin n_err++; $display("FAIL hit_done_width got %b want 0", rda); end
    n_vec++; if (hit_count !== 8'(exp_hit)) begin n_err++; $display("FAIL hit_count got %0d want %0d", hit_count, exp_hit); end
    n_vec++; if (miss_count !== 8'(exp_miss)) begin n_err++; $display("FAIL hit_misses got %0d want %0d", miss_count, exp_miss); end
    n_vec++; if (match !== 3'b111) begin n_err++; $display("FAIL match_hold got %b want 111", match); end
  endtask

  task automatic test_partial_match();
    bit found; logic [2:0] m; logic h, rdy, rda;
    load_challenge(6'b10_01_00);
    guess = 6'b10_00_00;
    press_wait(found, m, h, rdy, rda);
    exp_miss++;
    n_vec++; if (m !== 3'b101) begin n_err++; $display("FAIL miss_match got %b want 101", m); end
    n_vec++; if (h !== 1'b0) begin n_err++; $display("FAIL miss_hit got %b want 0", h); end
    n_vec++; if (miss_count !== 8'(exp_miss)) begin n_err++; $display("FAIL miss_count got %0d want %0d", miss_count, exp_miss); end
    n_vec++; if (hit_count !== 8'(exp_hit)) begin n_err++; $display("FAIL miss_hits got %0d want %0d", hit_count, exp_hit); end
  endtask

  task automatic test_timeout();
    bit found; logic [2:0] m; logic h, rdy, rda;
    load_challenge(6'b00_10_01);
    time_up = 1'b1;
    @(negedge clk);
    time_up = 1'b0;
    exp_miss++;
    n_vec++; if (round_done !== 1'b1) begin n_err++; $display("FAIL to_done got %b want 1", round_done); end
    n_vec++; if (match !== 3'b000) begin n_err++; $display("FAIL to_match got %b want 000", match); end
    n_vec++; if (miss_count !== 8'(exp_miss)) begin n_err++; $display("FAIL to_misses got %0d want %0d", miss_count, exp_miss); end
    n_vec++; if (chal_ready !== 1'b1) begin n_err++; $display("FAIL to_ready got %b want 1", chal_ready); end
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL to_hit got %b want 0", hit); end
    @(negedge clk);
    n_vec++; if (round_done !== 1'b0) begin n_err++; $display("FAIL to_done_width got %b want 0", round_done); end
    // Press while idle must be dropped.
    guess = 6'b00_10_01;
    press_wait(found, m, h, rdy, rda);
    n_vec++; if (found !== 1'b0) begin n_err++; $display("FAIL idle_press_done got %b want 0", found); end
    n_vec++; if ({hit_count, miss_count} !== {8'(exp_hit), 8'(exp_miss)}) begin
      n_err++; $display("FAIL idle_press_counts got %0d/%0d want %0d/%0d", hit_count, miss_count, exp_hit, exp_miss);
    end
  endtask

  task automatic test_bounce();
    int dones = 0;
    logic saw_hit = 1'b0;
    load_challenge(6'b01_01_10);
    guess = 6'b01_01_10;
    for (int i = 0; i < 40; i++) begin
      submit_n = (i < 2 || (i >= 3 && i < 9)) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (round_done) dones++;
      if (hit) saw_hit = 1'b1;
    end
    exp_hit++;
    n_vec++; if (dones !== 1) begin n_err++; $display("FAIL bounce_rounds got %0d want 1", dones); end
    n_vec++; if (saw_hit !== 1'b1) begin n_err++; $display("FAIL bounce_hit got %b want 1", saw_hit); end
    n_vec++; if (hit_count !== 8'(exp_hit)) begin n_err++; $display("FAIL bounce_hits got %0d want %0d", hit_count, exp_hit); end
  endtask

  task automatic test_press_vs_timeout();
    bit found = 1'b0;
    load_challenge(6'b10_10_10);
    guess = 6'b10_10_10;
    submit_n = 1'b0;
    repeat (6) @(negedge clk);
    // The debounced event is presented to the FSM on the very next edge.
    time_up = 1'b1;
    @(negedge clk);
    time_up = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (round_done) found = 1'b1;
    end
    submit_n = 1'b1;
    repeat (10) @(negedge clk);
    exp_hit++;
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL race_done got %b want 1", found); end
    n_vec++; if (hit_count !== 8'(exp_hit)) begin n_err++; $display("FAIL race_hits got %0d want %0d", hit_count, exp_hit); end
    n_vec++; if (miss_count !== 8'(exp_miss)) begin n_err++; $display("FAIL race_misses got %0d want %0d", miss_count, exp_miss); end
    n_vec++; if (match !== 3'b111) begin n_err++; $display("FAIL race_match got %b want 111", match); end
  endtask

  task automatic test_saturate_and_reset();
    bit found; logic [2:0] m; logic h, rdy, rda;
    while (exp_hit < 257) begin
      load_challenge(6'b00_01_10);
      guess = 6'b00_01_10;
      press_wait(found, m, h, rdy, rda);
      if (exp_hit < 255) exp_hit++;
      else exp_hit = exp_hit + 1;
    end
    n_vec++; if (hit_count !== 8'd255) begin n_err++; $display("FAIL sat_hits got %0d want 255", hit_count); end
    n_vec++; if (miss_count !== 8'(exp_miss)) begin n_err++; $display("FAIL sat_misses got %0d want %0d", miss_count, exp_miss); end
    load_challenge(6'b01_01_01);
    clear_b = 1'b0;
    #1;
    n_vec++; if (chal_ready !== 1'b1) begin n_err++; $display("FAIL armed_rst_ready got %b want 1", chal_ready); end
    n_vec++; if ({hit_count, miss_count} !== 16'd0) begin n_err++; $display("FAIL armed_rst_counts got %0d/%0d want 0/0", hit_count, miss_count); end
    n_vec++; if ({match, hit, round_done} !== 5'd0) begin n_err++; $display("FAIL armed_rst_outs got %b want 00000", {match, hit, round_done}); end
    @(negedge clk);
    clear_b = 1'b1;
    @(negedge clk);
    n_vec++; if (chal_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready got %b want 1", chal_ready); end
    exp_hit = 0; exp_miss = 0;
    load_challenge(6'b01_01_01);
    guess = 6'b01_01_01;
    press_wait(found, m, h, rdy, rda);
    exp_hit++;
    n_vec++; if (hit_count !== 8'(exp_hit)) begin n_err++; $display("FAIL after_rst_hits got %0d want %0d", hit_count, exp_hit); end
    n_vec++; if (m !== 3'b111) begin n_err++; $display("FAIL after_rst_match got %b want 111", m); end
  endtask

  initial begin
    test_reset();
    test_full_match();
    test_partial_match();
    test_timeout();
    test_bounce();
    test_press_vs_timeout();
    test_saturate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
